// File: rtl/keypad_if.sv
// Keypad-side signal bundle for keypad_scanner: the row/column matrix lines
// plus the decoded key code, its one-cycle strobe and the held indication.
interface keypad_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] digit;
    logic       digit_valid;
    logic       key_held;

    modport master (
        input  row_n,
        output col_n,
        output digit,
        output digit_valid,
        output key_held
    );

    modport slave (
        output row_n,
        input  col_n,
        input  digit,
        input  digit_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner. It walks a single low column,
// debounces both press and release, and presents every physical press
// exactly once as a registered key code with a one-cycle strobe.
module keypad_scanner #(
    parameter int SCAN_DIV  = 1000,
    parameter int DB_CYCLES = 20000
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DB_CYCLES) + 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] DB_ONE     = CW'(1);
    localparam logic [CW-1:0] DB_MAX     = '1;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [3:0]      row_meta, row_s;
    logic [DW-1:0]   dwell, dwell_next;
    logic [CW-1:0]   db_cnt, db_next, db_inc;
    logic [1:0]      col_idx, col_next;
    logic [1:0]      cap_row, cap_row_next;
    logic [1:0]      first_low;
    logic            cap_bit;
    logic            load_digit;
    logic [3:0]      digit;
    logic            digit_valid;

    // Row code lookup; the bottom row carries the * 0 # D symbols.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = 4'd10;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = 4'd11;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = 4'd12;
            4'b11_00: code = 4'd14;
            4'b11_01: code = 4'd0;
            4'b11_10: code = 4'd15;
            default:  code = 4'd13;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer: the rows are asynchronous to clk, idle high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta <= 4'hF;
            row_s    <= 4'hF;
        end else begin
            row_meta <= kp.row_n;
            row_s    <= row_meta;
        end
    end

    // Lowest-index low row wins when several keys share the driven column.
    always_comb begin
        first_low = 2'd3;
        if (!row_s[0])      first_low = 2'd0;
        else if (!row_s[1]) first_low = 2'd1;
        else if (!row_s[2]) first_low = 2'd2;
        cap_bit = row_s[cap_row];
        db_inc  = (db_cnt == DB_MAX) ? db_cnt : db_cnt + DB_ONE;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SCAN;
        else      state <= state_next;
    end

    // Next-state and datapath control; the column stays frozen outside SCAN.
    always_comb begin
        state_next   = state;
        dwell_next   = dwell;
        db_next      = db_cnt;
        col_next     = col_idx;
        cap_row_next = cap_row;
        load_digit   = 1'b0;
        case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_next = '0;
                    if (row_s != 4'hF) begin
                        cap_row_next = first_low;
                        db_next      = '0;
                        state_next   = DEBOUNCE;
                    end else begin
                        col_next = col_idx + 2'd1;
                    end
                end else begin
                    dwell_next = dwell + DWELL_ONE;
                end
            end
            DEBOUNCE: begin
                if (cap_bit) begin
                    state_next = SCAN;
                    col_next   = col_idx + 2'd1;
                    dwell_next = '0;
                    db_next    = '0;
                end else if (db_cnt == DB_LAST) begin
                    load_digit = 1'b1;
                    state_next = PRESSED;
                    db_next    = '0;
                end else begin
                    db_next = db_inc;
                end
            end
            PRESSED: begin
                if (cap_bit) begin
                    state_next = RELEASE;
                    db_next    = '0;
                end
            end
            RELEASE: begin
                if (!cap_bit) begin
                    db_next = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_next = SCAN;
                    col_next   = col_idx + 2'd1;
                    dwell_next = '0;
                    db_next    = '0;
                end else begin
                    db_next = db_inc;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // Counters, captured position and the registered code/strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell       <= '0;
            db_cnt      <= '0;
            col_idx     <= 2'd0;
            cap_row     <= 2'd0;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
        end else begin
            dwell       <= dwell_next;
            db_cnt      <= db_next;
            col_idx     <= col_next;
            cap_row     <= cap_row_next;
            digit_valid <= load_digit;
            if (load_digit) digit <= key_code(cap_row, col_idx);
        end
    end

    assign kp.col_n       = ~(4'b0001 << col_idx);
    assign kp.digit       = digit;
    assign kp.digit_valid = digit_valid;
    assign kp.key_held    = (state == PRESSED) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DB_CYCLES=8. A small
// matrix model turns pressed keys into row levels for the driven column.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] key_down;
    logic        rand_mode;
    logic [3:0]  rand_rows;
    logic [3:0]  tb_rows;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          pulse_cyc[$];
    logic [3:0]  pulse_dig[$];

    keypad_if kif ();

    keypad_scanner #(.SCAN_DIV(4), .DB_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number: cycle k is the interval after the k-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: a closed key pulls its row low while its column is low.
    always_comb begin
        tb_rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_down[r*4+c] && !kif.col_n[c]) tb_rows[r] = 1'b0;
    end
    assign kif.row_n = rand_mode ? rand_rows : tb_rows;

    // Log every strobe with its cycle and code, sampled mid-cycle.
    always @(negedge clk) begin
        if (kif.digit_valid) begin
            pulse_cyc.push_back(cyc);
            pulse_dig.push_back(kif.digit);
        end
    end

    function automatic int kidx(input int r, input int c);
        return r * 4 + c;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic clear_pulses();
        pulse_cyc.delete();
        pulse_dig.delete();
    endtask

    // Returns the first cycle of a fresh column-0 visit.
    task automatic sync_c0(output int e0);
        logic [3:0] prev;
        bit found;
        found = 0;
        prev  = kif.col_n;
        for (int i = 0; i < 64 && !found; i++) begin
            step(1);
            if (kif.col_n == 4'b1110 && prev != 4'b1110) found = 1;
            else prev = kif.col_n;
        end
        if (!found) begin
            checks++; failures++;
            $display("[TB] FAIL sync_c0: no column wrap seen, col_n=%b", kif.col_n);
        end
        e0 = cyc;
    endtask

    task automatic test_reset();
        int x;
        rst = 1'b0;
        rand_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_rows = 4'($urandom);
            step(1);
            checks++; if (kif.col_n !== 4'b1110) begin failures++; $display("[TB] FAIL reset_col_n: got %b want 1110", kif.col_n); end
            checks++; if (kif.digit !== 4'd0) begin failures++; $display("[TB] FAIL reset_digit: got %0d want 0", kif.digit); end
            checks++; if (kif.digit_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", kif.digit_valid); end
            checks++; if (kif.key_held !== 1'b0) begin failures++; $display("[TB] FAIL reset_held: got %b want 0", kif.key_held); end
        end
        rand_mode = 1'b0;
        step(2);
        rst = 1'b1;
        x = cyc;
        goto(x + 3);
        checks++; if (kif.col_n !== 4'b1110) begin failures++; $display("[TB] FAIL scan_c0_dwell: got %b want 1110", kif.col_n); end
        goto(x + 4);
        checks++; if (kif.col_n !== 4'b1101) begin failures++; $display("[TB] FAIL scan_c1: got %b want 1101", kif.col_n); end
        goto(x + 8);
        checks++; if (kif.col_n !== 4'b1011) begin failures++; $display("[TB] FAIL scan_c2: got %b want 1011", kif.col_n); end
        goto(x + 12);
        checks++; if (kif.col_n !== 4'b0111) begin failures++; $display("[TB] FAIL scan_c3: got %b want 0111", kif.col_n); end
        goto(x + 16);
        checks++; if (kif.col_n !== 4'b1110) begin failures++; $display("[TB] FAIL scan_wrap: got %b want 1110", kif.col_n); end
    endtask

    // Key "5" at r1,c1: sampled at e0+7, strobe at e0+16.
    task automatic test_clean_press();
        int e0, r;
        sync_c0(e0);
        clear_pulses();
        key_down[kidx(1, 1)] = 1'b1;
        goto(e0 + 15);
        checks++; if (kif.key_held !== 1'b0) begin failures++; $display("[TB] FAIL clean_held_early: got %b want 0", kif.key_held); end
        checks++; if (kif.digit !== 4'd0) begin failures++; $display("[TB] FAIL clean_digit_early: got %0d want 0", kif.digit); end
        goto(e0 + 16);
        checks++; if (kif.key_held !== 1'b1) begin failures++; $display("[TB] FAIL clean_held_rise: got %b want 1", kif.key_held); end
        checks++; if (kif.digit !== 4'd5) begin failures++; $display("[TB] FAIL clean_digit: got %0d want 5", kif.digit); end
        goto(e0 + 40);
        key_down = '0;
        r = cyc;
        goto(r + 10);
        checks++; if (kif.key_held !== 1'b1) begin failures++; $display("[TB] FAIL clean_held_release: got %b want 1", kif.key_held); end
        goto(r + 11);
        checks++; if (kif.key_held !== 1'b0) begin failures++; $display("[TB] FAIL clean_held_fall: got %b want 0", kif.key_held); end
        checks++; if (kif.col_n !== 4'b1011) begin failures++; $display("[TB] FAIL clean_resume_col: got %b want 1011", kif.col_n); end
        checks++; if (pulse_cyc.size() !== 1) begin failures++; $display("[TB] FAIL clean_pulse_count: got %0d want 1", pulse_cyc.size()); end
        if (pulse_cyc.size() >= 1) begin
            checks++; if (pulse_cyc[0] !== e0 + 16) begin failures++; $display("[TB] FAIL clean_pulse_cycle: got %0d want %0d", pulse_cyc[0], e0 + 16); end
            checks++; if (pulse_dig[0] !== 4'd5) begin failures++; $display("[TB] FAIL clean_pulse_digit: got %0d want 5", pulse_dig[0]); end
        end
    endtask

    // Key "#" at r3,c2 bounces: one aborted debounce, then a press at e0+37.
    task automatic test_bounce_press();
        int e0, r;
        int k;
        sync_c0(e0);
        clear_pulses();
        k = kidx(3, 2);
        goto(e0 + 7);  key_down[k] = 1'b1;
        goto(e0 + 10); key_down[k] = 1'b0;
        goto(e0 + 12);
        checks++; if (kif.col_n !== 4'b1011) begin failures++; $display("[TB] FAIL bounce_frozen: got %b want 1011", kif.col_n); end
        goto(e0 + 13); key_down[k] = 1'b1;
        checks++; if (kif.col_n !== 4'b0111) begin failures++; $display("[TB] FAIL bounce_abort_col: got %b want 0111", kif.col_n); end
        goto(e0 + 16); key_down[k] = 1'b0;
        goto(e0 + 19); key_down[k] = 1'b1;
        checks++; if (pulse_cyc.size() !== 0) begin failures++; $display("[TB] FAIL bounce_no_pulse: got %0d want 0", pulse_cyc.size()); end
        goto(e0 + 60);
        key_down = '0;
        r = cyc;
        goto(r + 12);
        checks++; if (kif.key_held !== 1'b0) begin failures++; $display("[TB] FAIL bounce_held_end: got %b want 0", kif.key_held); end
        checks++; if (pulse_cyc.size() !== 1) begin failures++; $display("[TB] FAIL bounce_pulse_count: got %0d want 1", pulse_cyc.size()); end
        if (pulse_cyc.size() >= 1) begin
            checks++; if (pulse_cyc[0] !== e0 + 37) begin failures++; $display("[TB] FAIL bounce_pulse_cycle: got %0d want %0d", pulse_cyc[0], e0 + 37); end
            checks++; if (pulse_dig[0] !== 4'd15) begin failures++; $display("[TB] FAIL bounce_pulse_digit: got %0d want 15", pulse_dig[0]); end
        end
    endtask

    // Key "0" at r3,c1 held long; the release bounces, final high run from r+13.
    task automatic test_long_hold();
        int e0, r;
        int k;
        sync_c0(e0);
        clear_pulses();
        k = kidx(3, 1);
        key_down[k] = 1'b1;
        goto(e0 + 15);
        checks++; if (kif.digit !== 4'd15) begin failures++; $display("[TB] FAIL hold_digit_kept: got %0d want 15", kif.digit); end
        goto(e0 + 200);
        checks++; if (kif.key_held !== 1'b1) begin failures++; $display("[TB] FAIL hold_held: got %b want 1", kif.key_held); end
        key_down[k] = 1'b0;
        r = cyc;
        goto(r + 3);  key_down[k] = 1'b1;
        goto(r + 6);  key_down[k] = 1'b0;
        goto(r + 9);  key_down[k] = 1'b1;
        goto(r + 11); key_down[k] = 1'b0;
        goto(r + 12);
        checks++; if (kif.key_held !== 1'b1) begin failures++; $display("[TB] FAIL hold_bounce_held: got %b want 1", kif.key_held); end
        goto(r + 20);
        checks++; if (kif.key_held !== 1'b1) begin failures++; $display("[TB] FAIL hold_held_late: got %b want 1", kif.key_held); end
        goto(r + 21);
        checks++; if (kif.key_held !== 1'b0) begin failures++; $display("[TB] FAIL hold_held_fall: got %b want 0", kif.key_held); end
        checks++; if (pulse_cyc.size() !== 1) begin failures++; $display("[TB] FAIL hold_pulse_count: got %0d want 1", pulse_cyc.size()); end
        if (pulse_cyc.size() >= 1) begin
            checks++; if (pulse_cyc[0] !== e0 + 16) begin failures++; $display("[TB] FAIL hold_pulse_cycle: got %0d want %0d", pulse_cyc[0], e0 + 16); end
            checks++; if (pulse_dig[0] !== 4'd0) begin failures++; $display("[TB] FAIL hold_pulse_digit: got %0d want 0", pulse_dig[0]); end
        end
    endtask

    // Digits 2, 0, 3, 4 entered one after another.
    task automatic test_sequence();
        int rs[4]  = '{0, 3, 0, 1};
        int cs[4]  = '{1, 1, 2, 0};
        int exd[4] = '{2, 0, 3, 4};
        int exc[4];
        int e0, r;
        clear_pulses();
        for (int i = 0; i < 4; i++) begin
            sync_c0(e0);
            exc[i] = e0 + 4 * cs[i] + 12;
            key_down[kidx(rs[i], cs[i])] = 1'b1;
            goto(exc[i] + 20);
            key_down = '0;
            r = cyc;
            goto(r + 12);
        end
        checks++; if (pulse_cyc.size() !== 4) begin failures++; $display("[TB] FAIL seq_pulse_count: got %0d want 4", pulse_cyc.size()); end
        for (int i = 0; i < 4 && i < pulse_cyc.size(); i++) begin
            checks++; if (pulse_dig[i] !== 4'(exd[i])) begin failures++; $display("[TB] FAIL seq_digit_%0d: got %0d want %0d", i, pulse_dig[i], exd[i]); end
            checks++; if (pulse_cyc[i] !== exc[i]) begin failures++; $display("[TB] FAIL seq_cycle_%0d: got %0d want %0d", i, pulse_cyc[i], exc[i]); end
            if (i > 0) begin
                checks++; if (pulse_cyc[i] - pulse_cyc[i-1] < 8) begin failures++; $display("[TB] FAIL seq_gap_%0d: got %0d want >=8", i, pulse_cyc[i] - pulse_cyc[i-1]); end
            end
        end
    endtask

    // Keys "4" and "7" share column 0; the lower row index must win.
    task automatic test_simultaneous();
        int e0, r;
        sync_c0(e0);
        clear_pulses();
        key_down[kidx(1, 0)] = 1'b1;
        key_down[kidx(2, 0)] = 1'b1;
        goto(e0 + 30);
        key_down = '0;
        r = cyc;
        goto(r + 12);
        checks++; if (pulse_cyc.size() !== 1) begin failures++; $display("[TB] FAIL simul_pulse_count: got %0d want 1", pulse_cyc.size()); end
        if (pulse_cyc.size() >= 1) begin
            checks++; if (pulse_dig[0] !== 4'd4) begin failures++; $display("[TB] FAIL simul_digit: got %0d want 4", pulse_dig[0]); end
            checks++; if (pulse_cyc[0] !== e0 + 12) begin failures++; $display("[TB] FAIL simul_cycle: got %0d want %0d", pulse_cyc[0], e0 + 12); end
        end
    endtask

    // Key "9" at r2,c2; reset lands mid-debounce and must cancel the press.
    task automatic test_reset_mid();
        int e0;
        sync_c0(e0);
        clear_pulses();
        key_down[kidx(2, 2)] = 1'b1;
        goto(e0 + 14);
        checks++; if (kif.col_n !== 4'b1011) begin failures++; $display("[TB] FAIL mid_frozen: got %b want 1011", kif.col_n); end
        rst = 1'b0;
        #1;
        checks++; if (kif.col_n !== 4'b1110) begin failures++; $display("[TB] FAIL mid_col_n: got %b want 1110", kif.col_n); end
        checks++; if (kif.digit !== 4'd0) begin failures++; $display("[TB] FAIL mid_digit: got %0d want 0", kif.digit); end
        checks++; if (kif.digit_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_valid: got %b want 0", kif.digit_valid); end
        checks++; if (kif.key_held !== 1'b0) begin failures++; $display("[TB] FAIL mid_held: got %b want 0", kif.key_held); end
        step(3);
        key_down = '0;
        step(1);
        rst = 1'b1;
        step(30);
        checks++; if (pulse_cyc.size() !== 0) begin failures++; $display("[TB] FAIL mid_no_pulse: got %0d want 0", pulse_cyc.size()); end
    endtask

    // Runs every scenario in order and prints the single summary line.
    initial begin
        rst       = 1'b0;
        key_down  = '0;
        rand_mode = 1'b0;
        rand_rows = 4'hF;
        test_reset();
        test_clean_press();
        test_bounce_press();
        test_long_hold();
        test_sequence();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: still running at cycle %0d, limit 20000", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces press and release, and emits one registered 4-bit key code with a single-cycle `digit_valid` strobe per physical press. It sits directly upstream of the password-entry FSM. `digit` drives that FSM's digit input, and `digit_valid` drives its enable input, so each press is presented exactly once.

## Interface
- `SCAN_DIV`, default 1000: clk cycles each column is driven low; must be ≥ 4.
- `DB_CYCLES`, default 20000: consecutive stable cycles required to accept a press or a release; must be ≥ 2.
- `clk`, input, 1: system clock; all logic on rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `row_n`, input, 4: keypad rows, active-low, externally pulled up; asynchronous to clk.
- `col_n`, output, 4: column drive, exactly one bit low at any time.
- `digit`, output, 4: code of the last accepted key; held until the next acceptance.
- `digit_valid`, output, 1: one-cycle pulse, coincident with the new `digit` value.
- `key_held`, output, 1: high while an accepted key remains pressed or its release is being debounced.

## Operation
- `row_n` passes through a 2-flop synchronizer (`row_s`); all decisions use `row_s` only.
- Key map (row r, column c → code):
  - r0: 1, 2, 3, A=10
  - r1: 4, 5, 6, B=11
  - r2: 7, 8, 9, C=12
  - r3: *=14, 0, #=15, D=13
- Column sequence: `col_n` = 1110 (c0), 1101 (c1), 1011 (c2), 0111 (c3), then wraps to c0.
- Dwell counter width is clog2(`SCAN_DIV`). Debounce counter width is clog2(`DB_CYCLES`)+1; it saturates and never wraps.
- **SCAN:** column advances when the dwell counter reaches `SCAN_DIV`-1. `row_s` is sampled only on that last dwell cycle.
  - If any `row_s` bit is 0: capture the column and the lowest-index low row, then go to DEBOUNCE. `col_n` is frozen.
  - Otherwise: advance the column.
- **DEBOUNCE:** count cycles while the captured row stays low in `row_s`.
  - Captured row goes high before the count completes: return to SCAN at the next column. No output.
  - Count reaches `DB_CYCLES`: load `digit`, pulse `digit_valid`, go to PRESSED.
- **PRESSED:** `key_held`=1; `col_n` stays frozen. When the captured row goes high, go to RELEASE.
- **RELEASE:** `key_held`=1. Count `DB_CYCLES` consecutive cycles of the captured row high.
  - Any low sample restarts the count; the state does not return to PRESSED and there is no new pulse.
  - When the count completes: `key_held`=0; return to SCAN, resuming at the next column with the dwell counter at 0.
- Multiple keys:
  - Same column: the lowest row index wins.
  - Other columns: invisible while frozen.
  - A second key held through release is detected on a later scan as a new press.
- Only DEBOUNCE→PRESSED produces `digit_valid`, giving one pulse per press regardless of hold time.

## Timing
- Reset values: `col_n`=1110, `digit`=0, `digit_valid`=0, `key_held`=0, state SCAN, both counters 0, synchronizer flops 1111.
- Reset asserted mid-operation (any state) returns to the reset values immediately. Any pending pulse is lost.
- Input latency: a `row_n` change is visible in `row_s` 2 cycles later.
- Press latency: let S be the sampling cycle that sees the low row. DEBOUNCE is entered at S+1, and `digit_valid` is high in cycle S+1+`DB_CYCLES`, for exactly 1 cycle.
- `digit` changes only in the `digit_valid` cycle.
- `key_held` rises in the same cycle as `digit_valid`. It falls `DB_CYCLES` cycles after the first of the final run of high samples in RELEASE.
- Press detection relative to physical contact: worst case 4·`SCAN_DIV`+2 cycles, plus `DB_CYCLES`.

## Test plan
Bench uses `SCAN_DIV`=4, `DB_CYCLES`=8.
- **Reset:** hold `rst`=0 with random `row_n` → `col_n`=1110, `digit`=0, `digit_valid`=0, `key_held`=0. Release reset → `col_n` steps through 1101, 1011, 0111 every 4 cycles, then wraps to 1110.
- **Clean press:** close key "5" (r1, c1) for 40 cycles → exactly one `digit_valid` with `digit`=5, exactly 8 cycles after DEBOUNCE entry. `key_held` stays high until 8 cycles after `row_s` returns high.
- **Bounce on press:** "#" (r3, c2) toggles every 3 cycles for 12 cycles, then stays closed → no pulse during bouncing; then one pulse with `digit`=15.
- **Bounce on release / long hold:** hold "0" for 200 cycles, then bounce on release → exactly one pulse with `digit`=0. No second pulse; `key_held`=0 only after 8 stable-high cycles.
- **Sequence into password FSM:** press 2, 0, 3, 4 in turn → four pulses with `digit`=2, 0, 3, 4, in order, at least 8 cycles apart.
- **Simultaneous keys / reset mid-press:**
  - Hold "4" and "7" together (c0, r1 and r2) → `digit`=4.
  - Assert `rst` during DEBOUNCE → no pulse, and the reset values appear immediately.
